// File: rtl/snap_capture_ctrl.sv
// rtl/snap_capture_ctrl.sv - one-shot snapshot BRAM capture sequencer
//
// Purpose: arms on a rising edge of the start bit in the control word. It then
// optionally waits for a trigger and writes len_m1+1 valid samples into the
// snapshot BRAM. It reports busy, done and a sample count for status readback.
//
// Ports:
//   user_clk, user_rst     fabric clock, synchronous active-high reset
//   ctrl_reg[31:0]         bit0 start (edge), bit1 use_trig, bit2 abort (level),
//                          bits[16 +: ADDR_W] len_m1
//   trig                   capture trigger from the datapath
//   din_valid, din         sample strobe and data
//   bram_we/addr/data      BRAM write port, one cycle after sample acceptance
//   busy                   high in ARMED or CAPTURE
//   done                   high once a capture has completed, until restart/abort
//   count                  samples written in the current or last capture
module snap_capture_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       ctrl_reg,
    input  logic              trig,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic              start_q;
    logic              start_edge;
    logic              abort;
    logic              use_trig;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] ptr;
    logic              last;
    logic              accept;
    logic              launch;

    assign start_edge = ctrl_reg[0] & ~start_q;
    assign abort      = ctrl_reg[2];
    assign use_trig   = ctrl_reg[1];

    // The write pointer always equals the number of samples already written,
    // so it is simply the low bits of count; the top bit only sets on the
    // final sample of a full-depth capture, after which no further writes occur.
    assign ptr  = count[ADDR_W-1:0];
    assign last = (ptr == len_q);

    // State register
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_edge) begin
                        state_d = use_trig ? S_ARMED : S_CAPTURE;
                    end
                end
                S_ARMED: begin
                    // A sample coincident with the trigger is sample 0, so a
                    // one-sample capture can finish straight from ARMED.
                    if (trig) begin
                        state_d = (din_valid && last) ? S_DONE : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (din_valid && last) begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output / control decode
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        accept = 1'b0;
        launch = 1'b0;
        case (state_q)
            S_ARMED:   busy = 1'b1;
            S_CAPTURE: busy = 1'b1;
            S_DONE:    done = 1'b1;
            default:   ;
        endcase
        if (!abort) begin
            accept = din_valid &&
                     ((state_q == S_CAPTURE) || ((state_q == S_ARMED) && trig));
            launch = start_edge && ((state_q == S_IDLE) || (state_q == S_DONE));
        end
    end

    // Datapath registers: start edge detect, length latch, write port, count
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            // start_q resets high so a start bit already set at reset release
            // does not launch a capture.
            start_q   <= 1'b1;
            len_q     <= '0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_data <= '0;
            count     <= '0;
        end else begin
            start_q <= ctrl_reg[0];
            bram_we <= accept;
            if (launch) begin
                len_q <= ctrl_reg[16 +: ADDR_W];
                count <= '0;
            end else if (accept) begin
                bram_addr <= ptr;
                bram_data <= din;
                count     <= count + {{ADDR_W{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// tb/tb_snap_capture_ctrl.sv - directed self-checking bench for snap_capture_ctrl
module tb_snap_capture_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic              user_clk;
    logic              user_rst;
    logic [31:0]       ctrl_reg;
    logic              trig;
    logic              din_valid;
    logic [DATA_W-1:0] din;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;

    int checks = 0;
    int errors = 0;

    snap_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .user_clk  (user_clk),
        .user_rst  (user_rst),
        .ctrl_reg  (ctrl_reg),
        .trig      (trig),
        .din_valid (din_valid),
        .din       (din),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_data (bram_data),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    function automatic logic [31:0] cw(input bit start, input bit use_trig,
                                       input bit abort, input int len_m1);
        logic [31:0] w;
        w = 32'h0;
        w[0] = start;
        w[1] = use_trig;
        w[2] = abort;
        w[16 +: ADDR_W] = len_m1[ADDR_W-1:0];
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    // Accept n consecutive samples (din = base+k) in CAPTURE, checking each write.
    task automatic burst(input string tag, input int n, input int base, input int addr0);
        for (int k = 0; k < n; k++) begin
            din_valid = 1'b1;
            din = base + k;
            step();
            check({tag, "_we"},    32'(bram_we),   32'd1);
            check({tag, "_addr"},  32'(bram_addr), 32'(addr0 + k));
            check({tag, "_data"},  32'(bram_data), 32'(base + k));
            check({tag, "_count"}, 32'(count),     32'(addr0 + k + 1));
        end
    endtask

    int wr_seen;
    int exp_addr;
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        user_rst  = 1'b1;
        ctrl_reg  = cw(1, 0, 0, 7);   // start already high across reset release
        trig      = 1'b0;
        din_valid = 1'b1;
        din       = 32'h0;
        step();
        step();
        check("rst_we",    32'(bram_we),   32'd0);
        check("rst_addr",  32'(bram_addr), 32'd0);
        check("rst_data",  32'(bram_data), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_count", 32'(count),     32'd0);

        // Start held high through reset release: must not fire
        user_rst = 1'b0;
        wr_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            wr_seen += int'(bram_we) + int'(busy);
        end
        check("held_start_no_fire", 32'(wr_seen), 32'd0);

        // ---- Free-run capture, len_m1=7 ----
        ctrl_reg = cw(0, 0, 0, 7);
        din_valid = 1'b0;
        step();
        ctrl_reg = cw(1, 0, 0, 7);
        din_valid = 1'b1;
        din = 32'hDEAD;               // start-edge cycle: not accepted
        step();
        check("fr_busy_start", 32'(busy),    32'd1);
        check("fr_we_start",   32'(bram_we), 32'd0);
        check("fr_count_clr",  32'(count),   32'd0);
        for (int k = 0; k < 8; k++) begin
            din = 32'h200 + k;
            step();
            check("fr_we",   32'(bram_we),   32'd1);
            check("fr_addr", 32'(bram_addr), 32'(k));
            check("fr_data", 32'(bram_data), 32'(32'h200 + k));
            check("fr_cnt",  32'(count),     32'(k + 1));
            check("fr_done", 32'(done),      32'(k == 7));
            check("fr_busy", 32'(busy),      32'(k != 7));
        end
        step();
        check("fr_post_we",   32'(bram_we), 32'd0);
        check("fr_post_done", 32'(done),    32'd1);
        check("fr_post_cnt",  32'(count),   32'd8);

        // ---- Triggered capture, len_m1=3, trig 20 cycles after start ----
        ctrl_reg = cw(0, 1, 0, 3);
        step();
        ctrl_reg = cw(1, 1, 0, 3);
        step();                       // start edge seen here
        check("tr_busy",  32'(busy), 32'd1);
        check("tr_done0", 32'(done), 32'd0);
        wr_seen = 0;
        for (int i = 0; i < 19; i++) begin
            din = 32'h900 + i;
            step();
            wr_seen += int'(bram_we);
        end
        check("tr_no_early_wr", 32'(wr_seen), 32'd0);
        trig = 1'b1;
        din = 32'h300;
        step();
        check("tr_we0",   32'(bram_we),   32'd1);
        check("tr_addr0", 32'(bram_addr), 32'd0);
        check("tr_data0", 32'(bram_data), 32'h300);
        trig = 1'b0;
        burst("tr", 3, 32'h301, 1);
        check("tr_done", 32'(done),  32'd1);
        check("tr_cnt",  32'(count), 32'd4);

        // ---- Gapped valid, len_m1=3 ----
        ctrl_reg = cw(0, 0, 0, 3);
        din_valid = 1'b0;
        step();
        ctrl_reg = cw(1, 0, 0, 3);
        step();
        exp_addr = 0;
        for (int i = 0; i < 7; i++) begin
            din_valid = pat[i];
            din = 32'h400 + i;
            step();
            check("gap_we", 32'(bram_we), 32'(pat[i]));
            if (pat[i]) begin
                check("gap_addr", 32'(bram_addr), 32'(exp_addr));
                check("gap_data", 32'(bram_data), 32'(32'h400 + i));
                exp_addr++;
            end
        end
        check("gap_done", 32'(done),  32'd1);
        check("gap_cnt",  32'(count), 32'd4);

        // ---- Abort and ignored restart, len_m1=15 ----
        ctrl_reg = cw(0, 0, 0, 15);
        din_valid = 1'b0;
        step();
        ctrl_reg = cw(1, 0, 0, 15);
        step();
        burst("ab", 5, 32'h500, 0);
        din_valid = 1'b0;
        ctrl_reg = cw(0, 0, 0, 15);
        step();
        ctrl_reg = cw(1, 0, 0, 15);   // edge during CAPTURE: ignored
        step();
        check("ab_restart_busy", 32'(busy),  32'd1);
        check("ab_restart_cnt",  32'(count), 32'd5);
        ctrl_reg = cw(1, 0, 1, 15);
        din_valid = 1'b1;             // valid during abort must not write
        din = 32'hBAD;
        step();
        check("ab_we",   32'(bram_we), 32'd0);
        check("ab_busy", 32'(busy),    32'd0);
        check("ab_done", 32'(done),    32'd0);
        check("ab_cnt",  32'(count),   32'd5);
        ctrl_reg = cw(0, 0, 0, 15);
        step();
        check("ab_idle_we",  32'(bram_we), 32'd0);
        check("ab_idle_cnt", 32'(count),   32'd5);

        // ---- New start after abort: full depth, 16 samples ----
        ctrl_reg = cw(1, 0, 0, 15);
        din_valid = 1'b0;
        step();
        check("fd_cnt_clr", 32'(count), 32'd0);
        check("fd_busy",    32'(busy),  32'd1);
        burst("fd", 16, 32'h600, 0);
        check("fd_done", 32'(done), 32'd1);
        din_valid = 1'b1;
        din = 32'h777;
        step();
        check("fd_nowrap_we",  32'(bram_we), 32'd0);
        check("fd_final_cnt",  32'(count),   32'd16);

        // ---- Reset mid-capture ----
        ctrl_reg = cw(0, 0, 0, 7);
        step();
        ctrl_reg = cw(1, 0, 0, 7);
        step();
        burst("mr", 3, 32'h800, 0);
        user_rst = 1'b1;
        step();
        check("mr_we",    32'(bram_we),   32'd0);
        check("mr_addr",  32'(bram_addr), 32'd0);
        check("mr_data",  32'(bram_data), 32'd0);
        check("mr_busy",  32'(busy),      32'd0);
        check("mr_done",  32'(done),      32'd0);
        check("mr_count", 32'(count),     32'd0);
        user_rst = 1'b0;
        step();
        step();
        check("mr_post_busy", 32'(busy),    32'd0);
        check("mr_post_we",   32'(bram_we), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
